mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_rr.sv | 21 ++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths and FSM states.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational two-way round-robin select; the grant history register lives in the caller.
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant
);

    // Lone requester wins; otherwise (both or neither) favour the port not granted last.
    always_comb begin
        grant = ~last_grant;
        if (valid0 && !valid1) begin
            grant = 1'b0;
        end else if (valid1 && !valid0) begin
            grant = 1'b1;
        end else begin
            grant = ~last_grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin request arbiter and access sequencer in front of a single-port memory
// with one-cycle registered read data; one access in flight at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out
);

    state_e                  state_r;
    state_e                  state_next_s;
    logic                    last_grant_r;
    logic                    port_r;
    logic                    write_r;
    logic                    grant_s;
    logic                    hs_s;
    logic                    sel_valid_s;
    logic                    sel_we_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;
    logic                    mem_we_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_data_r;
    logic                    p0_rsp_valid_r;
    logic                    p1_rsp_valid_r;
    logic [DATA_WIDTH-1:0]   p0_rsp_rdata_r;
    logic [DATA_WIDTH-1:0]   p1_rsp_rdata_r;

    rr_arbiter2 u_rr (
        .valid0     (p0_req_valid),
        .valid1     (p1_req_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // Request mux for the selected port, handshake and ready generation.
    always_comb begin
        sel_valid_s  = 1'b0;
        sel_we_s     = 1'b0;
        sel_addr_s   = '0;
        sel_wdata_s  = '0;
        if (grant_s == PORT_LSU) begin
            sel_valid_s = p1_req_valid;
            sel_we_s    = p1_req_we;
            sel_addr_s  = p1_req_addr;
            sel_wdata_s = p1_req_wdata;
        end else begin
            sel_valid_s = p0_req_valid;
            sel_we_s    = p0_req_we;
            sel_addr_s  = p0_req_addr;
            sel_wdata_s = p0_req_wdata;
        end
        hs_s         = (state_r == ST_IDLE) && sel_valid_s;
        p0_req_ready = (state_r == ST_IDLE) && (grant_s == PORT_FETCH);
        p1_req_ready = (state_r == ST_IDLE) && (grant_s == PORT_LSU);
    end

    // Next-state logic: accept, let memory sample, then capture its registered output.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS:  state_next_s = ST_CAPTURE;
            ST_CAPTURE: state_next_s = ST_IDLE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latch the accepted request onto the memory pins; write enable lives only in ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
            port_r       <= 1'b0;
            write_r      <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_data_r   <= '0;
        end else if (hs_s) begin
            last_grant_r <= grant_s;
            port_r       <= grant_s;
            write_r      <= sel_we_s;
            mem_we_r     <= sel_we_s;
            mem_addr_r   <= sel_addr_s;
            mem_data_r   <= sel_wdata_s;
        end else begin
            mem_we_r     <= 1'b0;
        end
    end

    // Completion strobe and read-data return to the granted port at the end of CAPTURE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rsp_valid_r <= 1'b0;
            p1_rsp_valid_r <= 1'b0;
            p0_rsp_rdata_r <= '0;
            p1_rsp_rdata_r <= '0;
        end else begin
            p0_rsp_valid_r <= (state_r == ST_CAPTURE) && (port_r == PORT_FETCH);
            p1_rsp_valid_r <= (state_r == ST_CAPTURE) && (port_r == PORT_LSU);
            if ((state_r == ST_CAPTURE) && !write_r && (port_r == PORT_FETCH)) begin
                p0_rsp_rdata_r <= mem_out;
            end
            if ((state_r == ST_CAPTURE) && !write_r && (port_r == PORT_LSU)) begin
                p1_rsp_rdata_r <= mem_out;
            end
        end
    end

    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_data     = mem_data_r;
    assign p0_rsp_valid = p0_rsp_valid_r;
    assign p1_rsp_valid = p1_rsp_valid_r;
    assign p0_rsp_rdata = p0_rsp_rdata_r;
    assign p1_rsp_rdata = p1_rsp_rdata_r;

endmodule
